// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the multi-channel clock divider.
//   state_e      : per-channel FSM state (IDLE=0, RUN=1)
//   MODE_TOGGLE  : 50%-duty square output
//   MODE_PULSE   : one-cycle strobe output
//   CNT_W_DEFAULT: default counter / divisor width
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int CNT_W_DEFAULT = 32;

  // Level of clk_out on a non-terminal cycle: a square wave holds,
  // a strobe returns low.
  function automatic logic hold_level(input logic mode_act, input logic cur);
    return (mode_act == MODE_PULSE) ? 1'b0 : cur;
  endfunction

  // Level of clk_out on a terminal cycle. If either the outgoing or the
  // incoming mode is a strobe, the terminal edge is the pulse (this also
  // makes a toggle->pulse switch emit its pulse on the switching edge).
  function automatic logic terminal_level(input logic mode_act,
                                          input logic mode_new,
                                          input logic cur);
    return ((mode_act == MODE_PULSE) || (mode_new == MODE_PULSE)) ? 1'b1 : ~cur;
  endfunction

  // Level of clk_out after a realign strobe: square waves restart high,
  // strobes restart low.
  function automatic logic sync_level(input logic mode_new);
    return (mode_new == MODE_TOGGLE) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One divider channel: IDLE/RUN FSM, period counter, latched divisor and mode.
// Divisor and mode are only taken at IDLE, terminal count or realign, so the
// output never produces a short or extra period.
// Ports:
//   basys_clock : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   en          : run enable (level)
//   m           : divisor; terminal count when cnt == m
//   mode        : 0 = toggle (square), 1 = pulse (strobe)
//   sync        : single-cycle realign strobe
//   clk_out     : registered divided clock / strobe
//   tick        : registered one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             basys_clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] m,
  input  logic             mode,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] m_act_q;
  logic             mode_act_q;
  logic             clk_out_q;
  logic             tick_q;

  logic [CNT_W-1:0] cnt_d;
  logic             terminal_d;

  // cnt never exceeds m_act, so the increment never wraps.
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign terminal_d = (cnt_q == m_act_q);

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      m_act_q    <= '0;
      mode_act_q <= MODE_TOGGLE;
      clk_out_q  <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= '0;
          m_act_q    <= m;
          mode_act_q <= mode;
          tick_q     <= 1'b0;
          clk_out_q  <= hold_level(mode_act_q, clk_out_q);
          if (en) begin
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!en) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= hold_level(mode_act_q, clk_out_q);
          end else if (sync) begin
            // Realign takes priority over terminal handling so that all
            // running channels restart their period on the same edge.
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            m_act_q    <= m;
            mode_act_q <= mode;
            clk_out_q  <= sync_level(mode);
          end else if (terminal_d) begin
            cnt_q      <= '0;
            tick_q     <= 1'b1;
            m_act_q    <= m;
            mode_act_q <= mode;
            clk_out_q  <= terminal_level(mode_act_q, mode, clk_out_q);
          end else begin
            cnt_q     <= cnt_d;
            tick_q    <= 1'b0;
            clk_out_q <= hold_level(mode_act_q, clk_out_q);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
// N_CH independent runtime-programmable clock dividers sharing one clock and
// one realign strobe.
// Ports:
//   basys_clock : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   en          : per-channel run enable
//   m           : packed divisors, channel i uses m[i*CNT_W +: CNT_W]
//   mode        : per-channel mode, 0 = toggle, 1 = pulse
//   sync        : realign strobe for every running channel
//   clk_out     : per-channel divided clock / strobe (registered)
//   tick        : per-channel terminal-count pulse (registered)
// -----------------------------------------------------------------------------
module multi_clock_divider
  import clk_div_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  basys_clock,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH*CNT_W-1:0] m,
  input  logic [N_CH-1:0]       mode,
  input  logic                  sync,
  output logic [N_CH-1:0]       clk_out,
  output logic [N_CH-1:0]       tick
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      clk_div_channel #(
        .CNT_W(CNT_W)
      ) u_ch (
        .basys_clock(basys_clock),
        .rst_n      (rst_n),
        .en         (en[gi]),
        .m          (m[gi*CNT_W +: CNT_W]),
        .mode       (mode[gi]),
        .sync       (sync),
        .clk_out    (clk_out[gi]),
        .tick       (tick[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
// Directed, table-driven bench for multi_clock_divider (4 channels, 8-bit
// divisors) with hand-written sequences for divisor change, realign, enable
// drop and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  basys_clock;
  logic                  rst_n;
  logic [N_CH-1:0]       en;
  logic [N_CH*CNT_W-1:0] m;
  logic [N_CH-1:0]       mode;
  logic                  sync;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;

  int checks = 0;
  int errors = 0;

  multi_clock_divider #(
    .N_CH (N_CH),
    .CNT_W(CNT_W)
  ) dut (
    .basys_clock(basys_clock),
    .rst_n      (rst_n),
    .en         (en),
    .m          (m),
    .mode       (mode),
    .sync       (sync),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  initial basys_clock = 1'b0;
  always #5 basys_clock = ~basys_clock;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  mode;
    logic [31:0] m;
    logic        sync;
    logic [3:0]  exp_clk;
    logic [3:0]  exp_tick;
  } vec_t;

  vec_t vecs[20];

  // Advance one clock edge and land 1 time unit after it.
  task automatic cyc();
    @(posedge basys_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = '0;
    mode  = '0;
    m     = '0;
    sync  = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic exp_c;
    logic exp_t;

    // ch0: m=3 mode 0; ch1: m=0 mode 0, switched to pulse at vector 12.
    vecs[0]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1111, 4'b0000};
    vecs[1]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1101, 4'b0010};
    vecs[2]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1111, 4'b0010};
    vecs[3]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1101, 4'b0010};
    vecs[4]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1110, 4'b0011};
    vecs[5]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1100, 4'b0010};
    vecs[6]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1110, 4'b0010};
    vecs[7]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1100, 4'b0010};
    vecs[8]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1111, 4'b0011};
    vecs[9]  = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1101, 4'b0010};
    vecs[10] = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1111, 4'b0010};
    vecs[11] = '{4'b0011, 4'b0000, 32'h0000_0003, 1'b0, 4'b1101, 4'b0010};
    vecs[12] = '{4'b0011, 4'b0010, 32'h0000_0003, 1'b0, 4'b1110, 4'b0011};
    vecs[13] = '{4'b0011, 4'b0010, 32'h0000_0003, 1'b0, 4'b1110, 4'b0010};
    vecs[14] = '{4'b0011, 4'b0010, 32'h0000_0003, 1'b0, 4'b1110, 4'b0010};
    vecs[15] = '{4'b0011, 4'b0010, 32'h0000_0003, 1'b0, 4'b1110, 4'b0010};
    vecs[16] = '{4'b0011, 4'b0010, 32'h0000_0003, 1'b0, 4'b1111, 4'b0011};
    vecs[17] = '{4'b0011, 4'b0010, 32'h0000_0003, 1'b0, 4'b1111, 4'b0010};
    vecs[18] = '{4'b0000, 4'b0010, 32'h0000_0003, 1'b0, 4'b1101, 4'b0000};
    vecs[19] = '{4'b0000, 4'b0000, 32'h0000_0003, 1'b0, 4'b1101, 4'b0000};

    // Reset state
    do_reset();
    chk("reset clk_out", 32'(clk_out), 32'h0000_000F);
    chk("reset tick", 32'(tick), 32'h0000_0000);

    // Table: basic division, m=0 toggle, toggle->pulse switch, enable drop
    for (int i = 0; i < 20; i++) begin
      en   = vecs[i].en;
      mode = vecs[i].mode;
      m    = vecs[i].m;
      sync = vecs[i].sync;
      cyc();
      $display("vec %0d en=%b mode=%b clk_out=%b tick=%b", i, en, mode, clk_out, tick);
      chk($sformatf("vec%0d clk_out", i), 32'(clk_out), 32'(vecs[i].exp_clk));
      chk($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
    end

    // Divisor change mid-period: 3 -> 9 two cycles in
    do_reset();
    en = 4'b0001;
    m  = 32'h0000_0003;
    for (int j = 0; j <= 24; j++) begin
      if (j == 2) m = 32'h0000_0009;
      cyc();
      exp_c = (j < 4) ? 1'b1 : (j < 14) ? 1'b0 : (j < 24) ? 1'b1 : 1'b0;
      exp_t = (j == 4) || (j == 14) || (j == 24);
      $display("mchg cyc %0d clk_out=%b tick=%b", j, clk_out, tick);
      chk($sformatf("mchg%0d clk_out", j), 32'(clk_out), {28'h0, 3'b111, exp_c});
      chk($sformatf("mchg%0d tick", j), 32'(tick), {31'h0, exp_t});
    end

    // Realign: ch0 and ch2 (m=4) started 2 cycles apart, sync at edge 6
    do_reset();
    m  = 32'h0004_0004;
    en = 4'b0001;
    for (int j = 0; j <= 11; j++) begin
      if (j == 2) en = 4'b0101;
      if (j == 6) sync = 1'b1;
      if (j == 7) sync = 1'b0;
      cyc();
      $display("sync cyc %0d clk_out=%b tick=%b", j, clk_out, tick);
      if (j == 5) begin
        chk("sync pre clk_out", 32'(clk_out), 32'h0000_000E);
        chk("sync pre tick", 32'(tick), 32'h0000_0001);
      end else if (j >= 6 && j <= 10) begin
        chk($sformatf("sync%0d clk_out", j), 32'(clk_out), 32'h0000_000F);
        chk($sformatf("sync%0d tick", j), 32'(tick), 32'h0000_0000);
      end else if (j == 11) begin
        chk("sync aligned clk_out", 32'(clk_out), 32'h0000_000A);
        chk("sync aligned tick", 32'(tick), 32'h0000_0005);
      end
    end

    // Enable drop mid-period (ch0 low), re-enable, first toggle m+1 later
    do_reset();
    m  = 32'h0000_0003;
    en = 4'b0001;
    for (int j = 0; j <= 18; j++) begin
      if (j == 6) en = 4'b0000;
      if (j == 10) en = 4'b0001;
      cyc();
      exp_c = (j < 4) ? 1'b1 : (j < 14) ? 1'b0 : (j < 18) ? 1'b1 : 1'b0;
      exp_t = (j == 4) || (j == 14) || (j == 18);
      $display("endrop cyc %0d en=%b clk_out=%b tick=%b", j, en, clk_out, tick);
      chk($sformatf("endrop%0d clk_out", j), 32'(clk_out), {28'h0, 3'b111, exp_c});
      chk($sformatf("endrop%0d tick", j), 32'(tick), {31'h0, exp_t});
    end

    // Asynchronous reset between edges while ch0 is low and ticking
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset clk_out=%b tick=%b", clk_out, tick);
    chk("async rst clk_out", 32'(clk_out), 32'h0000_000F);
    chk("async rst tick", 32'(tick), 32'h0000_0000);
    repeat (2) begin
      cyc();
      chk("rst held clk_out", 32'(clk_out), 32'h0000_000F);
      chk("rst held tick", 32'(tick), 32'h0000_0000);
    end
    en    = 4'b0000;
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      $display("post reset idle cyc %0d clk_out=%b tick=%b", j, clk_out, tick);
      chk($sformatf("postrst%0d clk_out", j), 32'(clk_out), 32'h0000_000F);
      chk($sformatf("postrst%0d tick", j), 32'(tick), 32'h0000_0000);
    end
    en = 4'b0001;
    for (int j = 0; j <= 4; j++) begin
      cyc();
      exp_c = (j < 4);
      exp_t = (j == 4);
      $display("restart cyc %0d clk_out=%b tick=%b", j, clk_out, tick);
      chk($sformatf("restart%0d clk_out", j), 32'(clk_out), {28'h0, 3'b111, exp_c});
      chk($sformatf("restart%0d tick", j), 32'(tick), {31'h0, exp_t});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised N-channel successor to the team's single-output clock divider. Each channel divides `basys_clock` by its own runtime divisor and produces either a 50%-duty toggled clock or a one-cycle strobe, plus a terminal-count tick. Divisor and mode changes apply only at period boundaries, so outputs never glitch. All channels can be phase-aligned with one strobe. The block feeds display refresh, debounce and animation timing logic.

## Interface
Parameters:
- `N_CH`, 4, number of independent channels (1..16)
- `CNT_W`, 32, counter and divisor width per channel

Ports:
- `basys_clock`  in  1  single system clock; all logic on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  N_CH  per-channel run enable, level
- `m`  in  N_CH*CNT_W  packed divisors; channel i uses `m[i*CNT_W +: CNT_W]`
- `mode`  in  N_CH  per channel: 0 = toggle (square), 1 = pulse (strobe)
- `sync`  in  1  single-cycle strobe; realigns every running channel
- `clk_out`  out  N_CH  divided clock (mode 0) or strobe (mode 1), registered
- `tick`  out  N_CH  one-cycle pulse per terminal count, registered

## Operation
- Per-channel state: `cnt` (CNT_W), `m_act` (CNT_W), `mode_act`, FSM state IDLE/RUN.
- Reset: state = IDLE, `cnt` = 0, `m_act` = 0, `mode_act` = 0, `clk_out` = all 1, `tick` = all 0.
- IDLE, every edge:
  - `cnt` <= 0; `m_act` <= m; `mode_act` <= mode; `tick` <= 0.
  - `clk_out` holds if `mode_act`=0, else <= 0.
  - If `en`=1, go to RUN.
- RUN, `en`=0: go to IDLE next edge; `cnt` <= 0; `tick` <= 0; `clk_out` holds (mode 0) or <= 0 (mode 1).
- RUN, `en`=1, terminal (`cnt` == `m_act`):
  - `cnt` <= 0; `tick` <= 1; reload `m_act` <= m and `mode_act` <= mode.
  - `clk_out` <= ~`clk_out` in mode 0, or <= 1 in mode 1.
- RUN, `en`=1, non-terminal: `cnt` <= `cnt`+1; `tick` <= 0; `clk_out` holds (mode 0) or <= 0 (mode 1).
- `sync`=1 overrides terminal and non-terminal handling for channels in RUN with `en`=1:
  - `cnt` <= 0; `tick` <= 0; reload `m_act` and `mode_act`.
  - `clk_out` <= 1 (mode 0) or 0 (mode 1).
  - Channels in IDLE ignore `sync`.
- Arithmetic: `cnt` is unsigned CNT_W. `cnt` never exceeds `m_act`, so it never wraps. The comparison is equality only.
- Mode 0 period = 2·(m+1) cycles with 50% duty. Mode 1 period = m+1 cycles with a one-cycle high pulse.
- m = 0: mode 0 toggles every cycle (basys_clock/2); mode 1 holds `clk_out` = 1 and `tick` = 1 continuously.
- A change on `m` or `mode` mid-period has no effect until the next terminal, `sync`, or IDLE pass.
- A mode switch applied at a terminal takes effect from the following cycle. A 0→1 switch leaves `clk_out` = 1 on the terminal edge (the pulse), then 0.

## Timing
- `en` sampled high at edge k (IDLE) → RUN from edge k.
- First terminal is at edge k+1+m. `clk_out` and `tick` change after that edge.
- `tick` is high exactly one cycle per terminal, coincident with the `clk_out` toggle (mode 0) or the pulse (mode 1).
- `sync` at edge s: all affected channels show `cnt`=0 after edge s. Their next terminal is edge s+1+m, so they are mutually phase-aligned.
- `rst_n` assertion mid-period clears all outputs asynchronously to reset values. After deassertion, channels start in IDLE.
- Output latency from state change is one register stage. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `clk_div_pkg`: state enum (IDLE=0, RUN=1), `MODE_TOGGLE`=0, `MODE_PULSE`=1, default `CNT_W`.
- Sub-module `clk_div_channel` (ports `basys_clock`, `rst_n`, `en`, `m`, `mode`, `sync`, `clk_out`, `tick`) holds one channel's FSM.
- `multi_clock_divider` instantiates N_CH copies via generate and slices `m`.

## Test plan
- Reset then `en`=1 on ch0 with m=3, mode 0 → `clk_out[0]` goes 1→0 at 4 cycles, then toggles every 4 cycles (period 8). `tick[0]` pulses every 4 cycles.
- ch1 with m=0 in mode 0 and mode 1 → toggles every cycle; in mode 1 `clk_out`=1 and `tick`=1 constantly.
- Change ch0 m from 3 to 9 two cycles into a period → current half-period stays 4 cycles, subsequent half-periods are 10. No short or extra pulse.
- ch0 (m=4) and ch2 (m=4) started 2 cycles apart, then `sync` pulsed → both `tick` outputs are coincident 5 cycles after `sync`, and `clk_out` is equal on both.
- `en` dropped mid-period in mode 0 → `clk_out` holds its level and `tick` stays 0. Re-enable → first toggle m+1 cycles after re-entry.
- `rst_n` low mid-count, asynchronous to the clock → `clk_out` = all 1 and `tick` = 0 immediately. After release, no output activity until `en` is asserted.
